// File: rtl/gpio_ctrl_pkg.sv
// ============================================================================
// Module : gpio_ctrl_pkg
// Brief  : Register map indices and address decode for gpio_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gpio_ctrl_pkg;

    typedef enum logic [2:0] {
        REG_IN   = 3'd0,
        REG_OUT  = 3'd1,
        REG_DIR  = 3'd2,
        REG_IE   = 3'd3,
        REG_IP   = 3'd4,
        REG_EDGE = 3'd5,
        REG_RSV6 = 3'd6,
        REG_RSV7 = 3'd7
    } reg_idx_e;

    localparam int c_BUS_W = 32;

    // Byte address to word index; the two low address bits are ignored.
    function automatic reg_idx_e reg_sel(input logic [4:0] adr);
        return reg_idx_e'(adr[4:2]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_pin_in.sv
// ============================================================================
// Module : gpio_pin_in
// Brief  : Per-pin 2-FF synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
//          rise/fall pulses of the accepted level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_pin_in
`ifdef GPIO_DEBOUNCE_EN
#(
    parameter int DEB_CNT = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
`ifdef GPIO_DEBOUNCE_EN
    input  logic tick_i,
`endif
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic w_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            prev_q  <= w_level;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int c_CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;

    logic               acc_q;
    logic [c_CNT_W-1:0] cnt_q;

    // Any tick that agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else if (tick_i) begin
            if (sync2_q != acc_q) begin
                if (cnt_q == c_CNT_W'(DEB_CNT - 1)) begin
                    acc_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign w_level = acc_q;
`else
    assign w_level = sync2_q;
`endif

    assign level_o = w_level;
    assign rise_o  = w_level & ~prev_q;
    assign fall_o  = ~w_level & prev_q;

endmodule

`default_nettype wire

// File: rtl/gpio_ctrl.sv
// ============================================================================
// Module : gpio_ctrl
// Brief  : Wishbone GPIO controller: direction/output regs, edge-latched W1C
//          pending bits, level IRQ. Debounce enabled by GPIO_DEBOUNCE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEB_DIV = 500,
    parameter int DEB_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    import gpio_ctrl_pkg::*;

    logic [WIDTH-1:0]   out_q, dir_q, ie_q, ip_q, edge_q, oe_q, gpo_q;
    logic [WIDTH-1:0]   ip_d;
    logic               ack_q, irq_q, primed_q;
    logic [c_BUS_W-1:0] dat_q;

    logic [WIDTH-1:0]   w_level, w_rise, w_fall, w_event, w_w1c, w_wdata;
    logic               w_acc, w_wr;
    reg_idx_e           w_sel;
    logic [c_BUS_W-1:0] w_rdata;
    logic               w_unused_bus;

    assign w_acc   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign w_wr    = w_acc & wb_we_i;
    assign w_sel   = reg_sel(wb_adr_i);
    assign w_wdata = wb_dat_i[WIDTH-1:0];
    assign w_event = primed_q ? ((w_rise & edge_q) | (w_fall & ~edge_q)) : '0;
    assign w_w1c   = (w_wr && (w_sel == REG_IP)) ? w_wdata : '0;
    // New events are OR-ed in after the clear so a coincident set wins.
    assign ip_d    = (ip_q & ~w_w1c) | w_event;

    assign w_unused_bus = ^{wb_adr_i[1:0], wb_dat_i};

`ifdef GPIO_DEBOUNCE_EN
    localparam int c_DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    logic [c_DIV_W-1:0] div_q;
    logic               tick_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (div_q == c_DIV_W'(DEB_DIV - 1)) begin
            div_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            div_q  <= div_q + 1'b1;
            tick_q <= 1'b0;
        end
    end
`else
    logic w_unused_deb;
    assign w_unused_deb = (DEB_DIV > 0) && (DEB_CNT > 0);
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_pin_in
`ifdef GPIO_DEBOUNCE_EN
        #(
            .DEB_CNT (DEB_CNT)
        )
`endif
        u_pin (
            .clk     (clk),
            .rst     (rst),
`ifdef GPIO_DEBOUNCE_EN
            .tick_i  (tick_q),
`endif
            .pin_i   (gpio_i[i]),
            .level_o (w_level[i]),
            .rise_o  (w_rise[i]),
            .fall_o  (w_fall[i])
        );
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_IN:   w_rdata[WIDTH-1:0] = w_level;
            REG_OUT:  w_rdata[WIDTH-1:0] = out_q;
            REG_DIR:  w_rdata[WIDTH-1:0] = dir_q;
            REG_IE:   w_rdata[WIDTH-1:0] = ie_q;
            REG_IP:   w_rdata[WIDTH-1:0] = ip_q;
            REG_EDGE: w_rdata[WIDTH-1:0] = edge_q;
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            out_q    <= '0;
            dir_q    <= '1;
            ie_q     <= '0;
            ip_q     <= '0;
            edge_q   <= '0;
            oe_q     <= '0;
            gpo_q    <= '0;
            irq_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            ack_q    <= w_acc;
            dat_q    <= (w_acc && !wb_we_i) ? w_rdata : '0;
            if (w_wr) begin
                case (w_sel)
                    REG_OUT:  out_q  <= w_wdata;
                    REG_DIR:  dir_q  <= w_wdata;
                    REG_IE:   ie_q   <= w_wdata;
                    REG_EDGE: edge_q <= w_wdata;
                    default:  ;
                endcase
            end
            ip_q     <= ip_d;
            oe_q     <= ~dir_q;
            gpo_q    <= out_q;
            irq_q    <= |(ip_q & ie_q);
            primed_q <= 1'b1;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign gpio_o   = gpo_q;
    assign gpio_oe  = oe_q;
    assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
// ============================================================================
// Module : tb_gpio_ctrl
// Brief  : Directed self-checking bench for gpio_ctrl (default build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpio_ctrl;

    localparam logic [4:0] c_IN   = 5'h00;
    localparam logic [4:0] c_OUT  = 5'h04;
    localparam logic [4:0] c_DIR  = 5'h08;
    localparam logic [4:0] c_IE   = 5'h0C;
    localparam logic [4:0] c_IP   = 5'h10;
    localparam logic [4:0] c_EDGE = 5'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [4:0]  wb_adr = '0;
    logic [31:0] wb_dat_w = '0;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic [7:0]  gpio_in, gpio_out, gpio_oe;
    logic        irq;
    logic [7:0]  ext = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    // Pads: driven pins loop back their output value, others follow ext.
    assign gpio_in = (gpio_out & gpio_oe) | (ext & ~gpio_oe);

    always #5 clk = ~clk;

    gpio_ctrl #(.WIDTH(8), .DEB_DIV(500), .DEB_CNT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (wb_cyc),
        .wb_stb_i (wb_stb),
        .wb_we_i  (wb_we),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_dat_w),
        .wb_dat_o (wb_dat_r),
        .wb_ack_o (wb_ack),
        .gpio_i   (gpio_in),
        .gpio_o   (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic bus(input logic we, input logic [4:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd);
        int n;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = wd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack && n < 8);
        check("ack_cycles", wb_ack ? n : 0, 1);
        rd = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(1'b1, adr, wd, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, adr, 32'h0, r);
        check(tag, r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;

        // Reset state
        check("rst_oe",  {24'h0, gpio_oe}, 32'h0);
        check("rst_o",   {24'h0, gpio_out}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_ack", {31'h0, wb_ack}, 32'h0);
        rd_chk("rst_IN",   c_IN,   32'h00);
        rd_chk("rst_OUT",  c_OUT,  32'h00);
        rd_chk("rst_DIR",  c_DIR,  32'hFF);
        rd_chk("rst_IE",   c_IE,   32'h00);
        rd_chk("rst_IP",   c_IP,   32'h00);
        rd_chk("rst_EDGE", c_EDGE, 32'h00);

        // Direction / output with loopback
        wr(c_DIR, 32'hF0);
        wr(c_OUT, 32'hAA);
        @(posedge clk); #1;
        check("oe_low_nibble", {24'h0, gpio_oe}, 32'h0F);
        check("gpio_o_AA",     {24'h0, gpio_out}, 32'hAA);
        repeat (3) @(posedge clk);
        rd_chk("IN_loop", c_IN,  32'h0A);
        rd_chk("DIR_F0",  c_DIR, 32'hF0);
        rd_chk("OUT_AA",  c_OUT, 32'hAA);

        // Rising edge on pin 7: IP at +3, irq at +4
        wr(c_IE,   32'h80);
        wr(c_EDGE, 32'h80);
        @(posedge clk); #1;
        ext[7] = 1'b1;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        check("irq_at_3", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_at_4", {31'h0, irq}, 32'h1);
        rd_chk("IP_set", c_IP, 32'h80);
        rd_chk("IN_pin7", c_IN, 32'h8A);
        wr(c_IP, 32'h80);
        rd_chk("IP_clr", c_IP, 32'h00);
        check("irq_clr", {31'h0, irq}, 32'h0);

        // W1C coinciding with a new rising edge: set wins
        ext[7] = 1'b0;
        repeat (5) @(posedge clk);
        rd_chk("IP_pre_race", c_IP, 32'h00);
        @(posedge clk); #1;
        ext[7] = 1'b1;
        @(posedge clk);
        wr(c_IP, 32'h80);
        rd_chk("IP_set_wins", c_IP, 32'h80);
        check("irq_after_race", {31'h0, irq}, 32'h1);
        wr(c_IP, 32'h80);
        rd_chk("IP_clr2", c_IP, 32'h00);

        // All inputs, OUT retained, falling edges latched with IE = 0
        ext = 8'h00;
        wr(c_DIR,  32'hFF);
        wr(c_EDGE, 32'h00);
        wr(c_IE,   32'h00);
        repeat (5) @(posedge clk);
        wr(c_IP, 32'hFF);
        rd_chk("IP_clr3", c_IP, 32'h00);
        rd_chk("OUT_kept", c_OUT, 32'hAA);
        check("oe_all_in",   {24'h0, gpio_oe}, 32'h00);
        check("gpio_o_kept", {24'h0, gpio_out}, 32'hAA);
        ext = 8'hAA;
        repeat (150) @(posedge clk);
        rd_chk("IN_AA", c_IN, 32'hAA);
        rd_chk("IP_no_rise", c_IP, 32'h00);
        ext = 8'h00;
        repeat (150) @(posedge clk);
        rd_chk("IN_00", c_IN, 32'h00);
        rd_chk("IP_falls", c_IP, 32'hAA);
        check("irq_ie0", {31'h0, irq}, 32'h0);
        ext = 8'hAA;
        repeat (150) @(posedge clk);
        rd_chk("IN_AA2", c_IN, 32'hAA);
        rd_chk("rsv_18", 5'h18, 32'h0);
        wr(5'h1C, 32'hFFFF_FFFF);
        rd_chk("rsv_1C", 5'h1C, 32'h0);
        rd_chk("OUT_after_rsv", c_OUT, 32'hAA);

        // Reset during a held strobe write to OUT
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = c_OUT; wb_dat_w = 32'h55;
        #2; rst = 1'b0;
        #1;
        check("midrst_ack", {31'h0, wb_ack}, 32'h0);
        @(posedge clk); #1;
        check("midrst_ack_held", {31'h0, wb_ack}, 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("midrst_o",   {24'h0, gpio_out}, 32'h00);
        check("midrst_oe",  {24'h0, gpio_oe}, 32'h00);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        rd_chk("midrst_OUT", c_OUT, 32'h00);
        rd_chk("midrst_DIR", c_DIR, 32'hFF);
        rd_chk("midrst_IP",  c_IP,  32'h00);
        rd_chk("midrst_IN",  c_IN,  32'hAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
